// File: rtl/sync_down_timer_pkg.sv
// counter_pkg: shared counter state encoding and default width
package counter_pkg;
  localparam int DEFAULT_CNT_WIDTH = 4;
  typedef enum logic {IDLE, RUN} state_e;
endpackage

// File: rtl/sync_down_timer_if.sv
// sync_down_timer_if: load handshake, controls and count/status outputs; master drives, slave is the timer
interface sync_down_timer_if #(parameter int WIDTH = 4);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_value;
  logic             auto_reload;
  logic             en;
  logic             abort;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             tc;
  modport master (output load_valid, load_value, auto_reload, en, abort, input load_ready, q, busy, tc);
  modport slave (input load_valid, load_value, auto_reload, en, abort, output load_ready, q, busy, tc);
endinterface

// File: rtl/sync_down_timer.sv
// sync_down_timer: loadable down-timer with one-shot/periodic tc pulse; ports clk, rst_n, bus (slave)
import counter_pkg::*;
module sync_down_timer #(parameter int WIDTH = DEFAULT_CNT_WIDTH) (
  input logic clk,
  input logic rst_n,
  sync_down_timer_if.slave bus
);
  state_e state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d, reload_q, reload_d;
  logic tc_q, tc_d, mode_q, mode_d;
  logic load, is_one, zero_ld;
  assign load = bus.load_valid && state_q == IDLE;
  assign is_one = q_q == WIDTH'(1);
  assign zero_ld = bus.load_value == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb
    state_d = state_q == IDLE ? ((load && !zero_ld) ? RUN : IDLE)
            : (bus.abort || (bus.en && is_one && !mode_q)) ? IDLE : RUN;
  always_comb begin
    bus.busy = state_q == RUN;
    bus.load_ready = state_q == IDLE;
    bus.q = q_q;
    bus.tc = tc_q;
  end
  always_comb begin
    q_d = q_q;
    reload_d = reload_q;
    mode_d = mode_q;
    tc_d = 1'b0;
    if (state_q == IDLE) begin
      if (load && zero_ld) begin
        tc_d = 1'b1;
        mode_d = 1'b0;
      end else if (load) begin
        q_d = bus.load_value;
        reload_d = bus.load_value;
        mode_d = bus.auto_reload;
      end
    end else if (bus.abort) begin
      q_d = '0;
      mode_d = 1'b0;
    end else if (bus.en) begin
      tc_d = is_one;
      q_d = is_one ? (mode_q ? reload_q : '0) : q_q - WIDTH'(1);
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q_q <= '0;
      reload_q <= '0;
      mode_q <= 1'b0;
      tc_q <= 1'b0;
    end else begin
      q_q <= q_d;
      reload_q <= reload_d;
      mode_q <= mode_d;
      tc_q <= tc_d;
    end
endmodule

// File: tb/tb_sync_down_timer.sv
// tb_sync_down_timer: directed self-checking bench for sync_down_timer
module tb_sync_down_timer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  sync_down_timer_if #(.WIDTH(4)) bus ();
  sync_down_timer #(.WIDTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic status(input string tag, input int q, input bit tc, input bit busy);
    check({tag, " q"}, 32'(bus.q), 32'(q));
    check({tag, " tc"}, 32'(bus.tc), 32'(tc));
    check({tag, " busy"}, 32'(bus.busy), 32'(busy));
    check({tag, " load_ready"}, 32'(bus.load_ready), 32'(!busy));
  endtask
  initial begin
    bus.load_valid = 1'b0;
    bus.load_value = '0;
    bus.auto_reload = 1'b0;
    bus.en = 1'b0;
    bus.abort = 1'b0;
    #12 rst_n = 1'b1;
    tick();
    status("post_reset", 0, 0, 0);
    bus.load_valid = 1'b1;
    bus.load_value = 4'd9;
    tick();
    bus.load_valid = 1'b0;
    status("load9", 9, 0, 1);
    #3 rst_n = 1'b0;
    #1 status("async_reset", 0, 0, 0);
    #2 rst_n = 1'b1;
    tick();
    status("after_reset_edge", 0, 0, 0);
    bus.load_valid = 1'b1;
    bus.load_value = 4'd5;
    bus.en = 1'b1;
    tick();
    bus.load_valid = 1'b0;
    status("oneshot_load", 5, 0, 1);
    for (int i = 4; i >= 0; i--) begin
      tick();
      status($sformatf("oneshot_q%0d", i), i, i == 0, i != 0);
    end
    tick();
    status("oneshot_tc_drop", 0, 0, 0);
    bus.load_valid = 1'b1;
    bus.load_value = 4'd3;
    bus.auto_reload = 1'b1;
    tick();
    bus.load_valid = 1'b0;
    bus.auto_reload = 1'b0;
    status("periodic_load", 3, 0, 1);
    for (int i = 1; i <= 10; i++) begin
      tick();
      status($sformatf("periodic_t%0d", i), 3 - (i % 3), (i % 3) == 0, 1);
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    status("periodic_abort", 0, 0, 0);
    bus.en = 1'b0;
    bus.load_valid = 1'b1;
    bus.load_value = 4'd4;
    tick();
    status("gated_load", 4, 0, 1);
    bus.load_value = 4'd9;
    begin
      automatic bit en_seq[7] = '{1, 0, 1, 0, 1, 0, 1};
      automatic int q_exp[7] = '{3, 3, 2, 2, 1, 1, 0};
      for (int i = 0; i < 7; i++) begin
        bus.en = en_seq[i];
        if (i == 4) bus.load_valid = 1'b0;
        tick();
        status($sformatf("gated_s%0d", i), q_exp[i], i == 6, i != 6);
      end
    end
    bus.en = 1'b0;
    tick();
    status("gated_idle", 0, 0, 0);
    bus.load_valid = 1'b1;
    bus.load_value = 4'd0;
    tick();
    bus.load_valid = 1'b0;
    status("zero_load", 0, 1, 0);
    tick();
    status("zero_after", 0, 0, 0);
    bus.load_valid = 1'b1;
    bus.load_value = 4'd2;
    bus.auto_reload = 1'b1;
    bus.en = 1'b1;
    tick();
    bus.load_valid = 1'b0;
    bus.auto_reload = 1'b0;
    status("abort_load2", 2, 0, 1);
    tick();
    status("abort_q1", 1, 0, 1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    status("abort_at_q1", 0, 0, 0);
    tick();
    status("abort_no_tc", 0, 0, 0);
    bus.abort = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_value = 4'd15;
    tick();
    bus.abort = 1'b0;
    bus.load_valid = 1'b0;
    status("load15_with_abort", 15, 0, 1);
    for (int i = 14; i >= 0; i--) begin
      tick();
      status($sformatf("max_q%0d", i), i, i == 0, i != 0);
    end
    tick();
    status("max_done", 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sync_down_timer.md
Name: sync_down_timer

Overview:
- Loadable synchronous down-counter/timer: the counting-down counterpart to the team's synchronous up counter.
- Accepts a start value over a valid/ready load handshake and decrements once per enabled clock.
- Pulses terminal count on reaching zero, and either stops or auto-reloads for periodic ticks.
- Sits beside the up counter as the timebase/event generator for downstream logic.

Parameters:
- WIDTH, 4, counter and load value width in bits (legal range 2..16).

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- load_valid  input  1  load request; qualifies load_value and auto_reload.
- load_ready  output  1  high when the block can accept a load (state IDLE); combinational from state.
- load_value  input  WIDTH  start count.
- auto_reload  input  1  sampled at load handshake; 1 = periodic mode.
- en  input  1  count enable; decrement only when high.
- abort  input  1  synchronous stop; returns to IDLE.
- q  output  WIDTH  current count, registered.
- busy  output  1  high in state RUN.
- tc  output  1  registered one-cycle terminal-count pulse.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, q=0, tc=0, busy=0, reload register=0, mode bit=0. load_ready=1 during and after reset.
- States: IDLE, RUN. busy = (state==RUN). load_ready = (state==IDLE).
- Handshake: a load fires on a rising edge with load_valid && load_ready. Loads presented while in RUN are ignored, not queued.
- IDLE, load fires, load_value!=0:
  - q<=load_value, reload_reg<=load_value, mode<=auto_reload, state->RUN.
  - en is not required on the load edge.
- IDLE, load fires, load_value==0:
  - q stays 0, tc<=1 for one cycle, state stays IDLE, mode<=0.
- RUN, en=0: hold q. tc<=0.
- RUN, en=1, q>1: q<=q-1. tc<=0.
- RUN, en=1, q==1, mode=0: q<=0, tc<=1, state->IDLE.
- RUN, en=1, q==1, mode=1: q<=reload_reg, tc<=1, stay RUN. Period is exactly reload_reg enabled cycles between tc pulses.
- tc is high for exactly one cycle, the cycle after the edge that caused it. It is 0 in every other cycle.
- abort=1 in RUN: state->IDLE, q<=0, tc<=0, mode<=0. abort has priority over the en decrement, including the q==1 case, so no tc is produced.
- abort in IDLE: no effect. Same-edge abort and load in IDLE: load wins (abort is a RUN-only control).
- Wrap-around: q never decrements below 0; no underflow path exists. Max load 2^WIDTH-1 is legal.
- Reset mid-RUN: immediate return to the reset values. Any pending tc is lost.
- Arithmetic: unsigned WIDTH-bit decrement. The compare against 1 is WIDTH bits wide.

Decomposition:
- Shared package counter_pkg:
  - state enum {IDLE, RUN}, reused by future counters.
  - Constant DEFAULT_CNT_WIDTH=4.
- No sub-module is required. Decrement/compare stays inline, and the FSM plus datapath live in one always block per register group.

Test Plan:
- Reset with q previously 9 (WIDTH=4) -> q=0, tc=0, busy=0, load_ready=1 asynchronously, before the next clk edge.
- Load 5, auto_reload=0, en held 1 -> q sequence 5,4,3,2,1,0; tc high only in the cycle q first reads 0; busy falls in the same cycle; load_ready=1.
- Load 3, auto_reload=1, en=1 for 10 cycles -> q 3,2,1,3,2,1,3,...; tc pulses every 3rd cycle; busy stays 1.
- Load 4, en toggled 1,0,1,0 -> q decrements only on enabled edges (4,3,3,2,2); tc appears after the 4th enabled edge; load_valid asserted mid-run is ignored (q unaffected).
- Load 0 -> tc single pulse on the next cycle; state remains IDLE; q=0; busy never asserts.
- Load 2 periodic, assert abort on the edge where q==1 and en=1 -> q=0, no tc, busy=0; a subsequent load of 15 runs 15 down to 0 and produces tc.
